// File: rtl/raw_tx_packetizer_if.sv
// Stream-in / packet-out handshake bundle of the raw TX packetizer.
// master: the packetizer side; slave: the application and packet-engine side.
interface raw_tx_packetizer_if #(
  parameter int unsigned DWIDTH      = 64,
  parameter int unsigned TXLEN_WIDTH = 11
);
  logic [DWIDTH-1:0]      in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   tx_req;
  logic [TXLEN_WIDTH-1:0] tx_len;
  logic                   tx_ack;
  logic                   tx_data_gate;
  logic [DWIDTH-1:0]      tx_data;

  modport master (
    input  in_data, in_valid, tx_ack, tx_data_gate,
    output in_ready, tx_req, tx_len, tx_data
  );

  modport slave (
    output in_data, in_valid, tx_ack, tx_data_gate,
    input  in_ready, tx_req, tx_len, tx_data
  );
endinterface

// File: rtl/raw_tx_packetizer.sv
// Buffers application words in a show-ahead FIFO and frames them into packets
// for the raw gateway TX path: full packets of PKT_WORDS, or an idle-timeout flush.
module raw_tx_packetizer #(
  parameter int unsigned NUM_BYTE      = 8,
  parameter int unsigned MAX_ONE_TXLEN = 1024,
  parameter int unsigned PKT_WORDS     = 128,
  parameter int unsigned FIFO_AW       = 8,
  parameter int unsigned FLUSH_CYCLES  = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  raw_tx_packetizer_if.master  bus,
  output logic [FIFO_AW:0]     fifo_level,
  output logic [15:0]          pkt_count,
  output logic                 underrun
);

  localparam int unsigned DWIDTH      = NUM_BYTE * 8;
  localparam int unsigned TXLEN_WIDTH = $clog2(MAX_ONE_TXLEN) + 1;
  localparam int unsigned DEPTH       = 1 << FIFO_AW;
  localparam int unsigned LVL_W       = FIFO_AW + 1;
  localparam int unsigned IDLE_W      = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [LVL_W-1:0]       LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]       LVL_PKT  = LVL_W'(PKT_WORDS);
  localparam logic [IDLE_W-1:0]      IDLE_MAX = IDLE_W'(FLUSH_CYCLES);
  localparam logic [TXLEN_WIDTH-1:0] LEN_MUL  = TXLEN_WIDTH'(NUM_BYTE);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND, S_DONE} state_t;

  state_t              state;
  logic [DWIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW-1:0]  rd_next;
  logic [LVL_W-1:0]    level_next;
  logic [LVL_W-1:0]    words_left;
  logic [LVL_W-1:0]    start_n;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                tx_ack_d;
  logic                ack_rise;
  logic                push;
  logic                pop;
  logic                start;

  // The first gate pulse coincides with the grant edge, so it is honoured in REQ too.
  assign ack_rise   = bus.tx_ack & ~tx_ack_d;
  assign push       = bus.in_valid & bus.in_ready;
  assign pop        = bus.tx_data_gate & (words_left != '0) &
                      ((state == S_SEND) | ((state == S_REQ) & ack_rise));
  assign rd_next    = rd_ptr + FIFO_AW'(pop);
  assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);

  // Packet-open decision: a full packet wins over an idle flush.
  always_comb begin
    start   = 1'b0;
    start_n = LVL_PKT;
    if (state == S_IDLE) begin
      if (fifo_level >= LVL_PKT) begin
        start = 1'b1;
      end else if ((FLUSH_CYCLES != 0) && (idle_cnt == IDLE_MAX) && (fifo_level != '0)) begin
        start   = 1'b1;
        start_n = fifo_level;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // FIFO pointers, level and the registered show-ahead head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      bus.in_ready <= 1'b0;
      bus.tx_data  <= '0;
    end else begin
      wr_ptr       <= wr_ptr + FIFO_AW'(push);
      rd_ptr       <= rd_next;
      fifo_level   <= level_next;
      bus.in_ready <= (level_next != LVL_FULL);
      // The new head slot is being written this very cycle: bypass the array.
      if (push && (fifo_level == LVL_W'(pop))) begin
        bus.tx_data <= bus.in_data;
      end else if (level_next != '0) begin
        bus.tx_data <= mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tx_ack_d    <= 1'b0;
      bus.tx_req  <= 1'b0;
      bus.tx_len  <= '0;
      words_left  <= '0;
      idle_cnt    <= '0;
      pkt_count   <= '0;
      underrun    <= 1'b0;
    end else begin
      tx_ack_d <= bus.tx_ack;

      if (push) begin
        idle_cnt <= '0;
      end else if ((state == S_IDLE) && (fifo_level != '0) && (idle_cnt != IDLE_MAX)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      if (pop) words_left <= words_left - LVL_W'(1);

      if (bus.tx_data_gate && ((state == S_SEND) || (state == S_DONE)) && (words_left == '0)) begin
        underrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_REQ;
            bus.tx_req <= 1'b1;
            bus.tx_len <= TXLEN_WIDTH'(start_n) * LEN_MUL;
            words_left <= start_n;
          end
        end
        S_REQ, S_SEND: begin
          if ((state == S_SEND) || ack_rise) begin
            state <= S_SEND;
            if (pop && (words_left == LVL_W'(1))) begin
              state      <= S_DONE;
              bus.tx_req <= 1'b0;
              pkt_count  <= pkt_count + 16'd1;
            end
          end
        end
        S_DONE: begin
          if (!bus.tx_ack) begin
            state    <= S_IDLE;
            idle_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
